// File: rtl/ll_pkg.sv
// Shared constants, width helpers and the per-entry event bundle
// for the LL/SC reservation monitor.
package ll_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  typedef struct packed {
    logic kill;
    logic set;
    logic clr;
  } entry_ev_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tmr_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] granule(input logic [MAX_ADDR_W-1:0] addr,
                                                    input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/ll_entry.sv
// One channel's link reservation: valid bit, granule tag and lifetime timer.
// Event priority: kill > set > clear > timeout.
module ll_entry
  import ll_pkg::*;
#(
  parameter int unsigned TAG_W   = 28,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned TMR_W  = tmr_width(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  entry_ev_t        ev,
  input  logic [TAG_W-1:0] set_tag,
  output logic             valid,
  output logic [TAG_W-1:0] tag
);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      timer <= '0;
    end else if (ev.kill) begin
      valid <= 1'b0;
    end else if (ev.set) begin
      valid <= 1'b1;
      tag   <= set_tag;
      timer <= TMR_W'(TIMEOUT);
    end else if (ev.clr) begin
      valid <= 1'b0;
    end else if ((TIMEOUT != 0) && valid) begin
      // Timer reaching 1 at an edge ends the lifetime exactly TIMEOUT edges after the LL.
      if (timer == TMR_W'(1)) valid <= 1'b0;
      else                    timer <= timer - TMR_W'(1);
    end
  end

endmodule

// File: rtl/ll_monitor.sv
// LL/SC reservation monitor: per-channel reservations, store snooping,
// and a registered SC pass/fail result.
module ll_monitor
  import ll_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GRAN_LSB = 4,
  parameter int unsigned TIMEOUT  = 255,
  localparam int unsigned CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ll_valid,
  input  logic [CH_W-1:0]   ll_ch,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_valid,
  input  logic [CH_W-1:0]   sc_ch,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic              st_valid,
  input  logic [CH_W-1:0]   st_ch,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [NUM_CH-1:0] excep,
  output logic              sc_ok_valid,
  output logic              sc_ok,
  output logic [NUM_CH-1:0] llbit_o
);

  localparam int unsigned TAG_W = ADDR_W - GRAN_LSB;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    logic [MAX_ADDR_W-1:0] wide;
    wide = '0;
    wide[ADDR_W-1:0] = addr;
    return TAG_W'(granule(wide, GRAN_LSB));
  endfunction

  logic [TAG_W-1:0]  ll_tag, sc_tag, st_tag;
  logic              st_in;
  logic [NUM_CH-1:0] valid;
  logic [TAG_W-1:0]  tags [NUM_CH];

  assign ll_tag = tag_of(ll_addr);
  assign sc_tag = tag_of(sc_addr);
  assign st_tag = tag_of(st_addr);
  assign st_in  = (32'(st_ch) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    entry_ev_t ev;
    always_comb begin
      ev      = '0;
      ev.kill = excep[g];
      ev.set  = ll_valid && (ll_ch == CH_W'(g));
      // Another channel's store into this reservation's granule breaks the link.
      ev.clr  = (sc_valid && (sc_ch == CH_W'(g))) ||
                (st_valid && st_in && (st_ch != CH_W'(g)) && valid[g] && (tags[g] == st_tag));
    end

    ll_entry #(
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .ev      (ev),
      .set_tag (ll_tag),
      .valid   (valid[g]),
      .tag     (tags[g])
    );
  end

  logic             sel_v, sel_ex, sc_pass;
  logic [TAG_W-1:0] sel_tag;

  // Out-of-range sc_ch selects nothing, so the SC fails.
  always_comb begin
    sel_v   = 1'b0;
    sel_ex  = 1'b0;
    sel_tag = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sc_ch == CH_W'(c)) begin
        sel_v   = valid[c];
        sel_ex  = excep[c];
        sel_tag = tags[c];
      end
    end
    sc_pass = sel_v && (sel_tag == sc_tag) && !sel_ex &&
              !(st_valid && st_in && (st_ch != sc_ch) && (st_tag == sel_tag));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_ok_valid <= 1'b0;
      sc_ok       <= 1'b0;
    end else begin
      sc_ok_valid <= sc_valid;
      sc_ok       <= sc_valid && sc_pass;
    end
  end

  assign llbit_o = valid;

endmodule

// File: tb/tb_ll_monitor.sv
// Directed self-checking bench for ll_monitor (2 channels, 16-byte granules, 4-cycle lifetime).
module tb_ll_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ll_valid, sc_valid, st_valid;
  logic [0:0]  ll_ch, sc_ch, st_ch;
  logic [31:0] ll_addr, sc_addr, st_addr;
  logic [1:0]  excep;
  logic        sc_ok_valid, sc_ok;
  logic [1:0]  llbit_o;

  int n_checks = 0;
  int n_fail   = 0;

  ll_monitor #(
    .NUM_CH   (2),
    .ADDR_W   (32),
    .GRAN_LSB (4),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ll_valid    (ll_valid),
    .ll_ch       (ll_ch),
    .ll_addr     (ll_addr),
    .sc_valid    (sc_valid),
    .sc_ch       (sc_ch),
    .sc_addr     (sc_addr),
    .st_valid    (st_valid),
    .st_ch       (st_ch),
    .st_addr     (st_addr),
    .excep       (excep),
    .sc_ok_valid (sc_ok_valid),
    .sc_ok       (sc_ok),
    .llbit_o     (llbit_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ll_valid = 1'b0; ll_ch = '0; ll_addr = '0;
    sc_valid = 1'b0; sc_ch = '0; sc_addr = '0;
    st_valid = 1'b0; st_ch = '0; st_addr = '0;
    excep    = '0;
  endtask

  task automatic clear_all();
    idle();
    excep = 2'b11;
    tick();
    idle();
  endtask

  task automatic do_ll(input logic ch, input logic [31:0] a);
    ll_valid = 1'b1; ll_ch = ch; ll_addr = a;
  endtask

  task automatic do_sc(input logic ch, input logic [31:0] a);
    sc_valid = 1'b1; sc_ch = ch; sc_addr = a;
  endtask

  task automatic do_st(input logic ch, input logic [31:0] a);
    st_valid = 1'b1; st_ch = ch; st_addr = a;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    do_sc(1'b0, 32'h1000);
    #1;
    n_checks++; if (llbit_o !== 2'b00) begin n_fail++; $display("FAIL reset_llbit: got %b expected 00", llbit_o); end
    n_checks++; if (sc_ok_valid !== 1'b0) begin n_fail++; $display("FAIL reset_okv: got %b expected 0", sc_ok_valid); end
    tick(); tick();
    n_checks++; if (sc_ok_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sc_held: got %b expected 0", sc_ok_valid); end
    rst_n = 1'b1;
    idle();
    tick();
    n_checks++; if (sc_ok_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_okv: got %b expected 0", sc_ok_valid); end
    n_checks++; if (sc_ok !== 1'b0) begin n_fail++; $display("FAIL reset_release_ok: got %b expected 0", sc_ok); end
  endtask

  task automatic test_ll_sc();
    clear_all();
    do_ll(1'b0, 32'h1000); tick(); idle();
    n_checks++; if (llbit_o !== 2'b01) begin n_fail++; $display("FAIL llsc_llbit: got %b expected 01", llbit_o); end
    do_sc(1'b0, 32'h1008); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1) begin n_fail++; $display("FAIL llsc_okv: got %b expected 1", sc_ok_valid); end
    n_checks++; if (sc_ok !== 1'b1) begin n_fail++; $display("FAIL llsc_ok: got %b expected 1", sc_ok); end
    n_checks++; if (llbit_o[0] !== 1'b0) begin n_fail++; $display("FAIL llsc_llbit_after: got %b expected 0", llbit_o[0]); end
    tick();
    n_checks++; if (sc_ok_valid !== 1'b0) begin n_fail++; $display("FAIL llsc_okv_drop: got %b expected 0", sc_ok_valid); end
  endtask

  task automatic test_store_snoop();
    clear_all();
    do_ll(1'b0, 32'h1000); tick(); idle();
    do_st(1'b1, 32'h100C); tick(); idle();
    n_checks++; if (llbit_o[0] !== 1'b0) begin n_fail++; $display("FAIL st_other_kill: got %b expected 0", llbit_o[0]); end
    do_sc(1'b0, 32'h1000); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b0) begin n_fail++; $display("FAIL st_other_sc: got %b%b expected 10", sc_ok_valid, sc_ok); end
    do_ll(1'b0, 32'h1000); tick(); idle();
    do_st(1'b1, 32'h1010); tick(); idle();
    n_checks++; if (llbit_o[0] !== 1'b1) begin n_fail++; $display("FAIL st_diff_gran: got %b expected 1", llbit_o[0]); end
    do_st(1'b0, 32'h100C); tick(); idle();
    n_checks++; if (llbit_o[0] !== 1'b1) begin n_fail++; $display("FAIL st_own: got %b expected 1", llbit_o[0]); end
    do_sc(1'b0, 32'h1000); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b1) begin n_fail++; $display("FAIL st_own_sc: got %b%b expected 11", sc_ok_valid, sc_ok); end
  endtask

  task automatic test_excep();
    clear_all();
    do_ll(1'b1, 32'h2000); excep = 2'b10; tick(); idle();
    n_checks++; if (llbit_o[1] !== 1'b0) begin n_fail++; $display("FAIL exc_llbit: got %b expected 0", llbit_o[1]); end
    do_sc(1'b1, 32'h2000); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b0) begin n_fail++; $display("FAIL exc_sc: got %b%b expected 10", sc_ok_valid, sc_ok); end
    do_ll(1'b0, 32'h2000); tick(); idle();
    do_sc(1'b0, 32'h2000); excep = 2'b01; tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b0) begin n_fail++; $display("FAIL exc_same_sc: got %b%b expected 10", sc_ok_valid, sc_ok); end
  endtask

  task automatic test_timeout();
    clear_all();
    do_ll(1'b0, 32'h1000); tick(); idle();
    n_checks++; if (llbit_o[0] !== 1'b1) begin n_fail++; $display("FAIL tmo_edge0: got %b expected 1", llbit_o[0]); end
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++; if (llbit_o[0] !== 1'b1) begin n_fail++; $display("FAIL tmo_edge%0d: got %b expected 1", e, llbit_o[0]); end
    end
    tick();
    n_checks++; if (llbit_o[0] !== 1'b0) begin n_fail++; $display("FAIL tmo_edge4: got %b expected 0", llbit_o[0]); end
    do_sc(1'b0, 32'h1000); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b0) begin n_fail++; $display("FAIL tmo_sc: got %b%b expected 10", sc_ok_valid, sc_ok); end
  endtask

  task automatic test_same_cycle();
    clear_all();
    do_ll(1'b0, 32'h3000); tick(); idle();
    do_sc(1'b0, 32'h3000); do_st(1'b1, 32'h3004); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b0) begin n_fail++; $display("FAIL sc_st_race: got %b%b expected 10", sc_ok_valid, sc_ok); end
    do_ll(1'b0, 32'h6000); tick(); idle();
    do_ll(1'b0, 32'h7000); do_sc(1'b0, 32'h6000); tick(); idle();
    n_checks++; if (sc_ok !== 1'b1 || llbit_o[0] !== 1'b1) begin n_fail++; $display("FAIL ll_over_sc: got ok=%b llbit=%b expected ok=1 llbit=1", sc_ok, llbit_o[0]); end
    do_sc(1'b0, 32'h7000); tick(); idle();
    n_checks++; if (sc_ok !== 1'b1 || llbit_o[0] !== 1'b0) begin n_fail++; $display("FAIL ll_over_sc_new: got ok=%b llbit=%b expected ok=1 llbit=0", sc_ok, llbit_o[0]); end
  endtask

  task automatic test_reset_mid();
    clear_all();
    do_ll(1'b0, 32'h4000); tick(); idle();
    do_ll(1'b1, 32'h5000); tick(); idle();
    n_checks++; if (llbit_o !== 2'b11) begin n_fail++; $display("FAIL rmid_both: got %b expected 11", llbit_o); end
    do_sc(1'b1, 32'h5000); tick(); idle();
    n_checks++; if (sc_ok_valid !== 1'b1 || sc_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_sc: got %b%b expected 11", sc_ok_valid, sc_ok); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (sc_ok_valid !== 1'b0 || sc_ok !== 1'b0 || llbit_o !== 2'b00) begin n_fail++; $display("FAIL rmid_async: got okv=%b ok=%b llbit=%b expected all 0", sc_ok_valid, sc_ok, llbit_o); end
    do_sc(1'b0, 32'h4000); tick();
    n_checks++; if (sc_ok_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_sc_in_reset: got %b expected 0", sc_ok_valid); end
    rst_n = 1'b1; idle(); tick();
    n_checks++; if (sc_ok_valid !== 1'b0 || llbit_o !== 2'b00) begin n_fail++; $display("FAIL rmid_release: got okv=%b llbit=%b expected 0 00", sc_ok_valid, llbit_o); end
  endtask

  initial begin
    test_reset();
    test_ll_sc();
    test_store_snoop();
    test_excep();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
